// File: rtl/control_unit_if.sv
// Control-unit to datapath bundle: instruction, fetch handshake and every control strobe.
// The sequencer drives this bundle through the master modport; the datapath uses the slave modport.
interface control_unit_if #(
    parameter int NREGS  = 16,
    parameter int OPW    = 5,
    parameter int DATA_W = 32
);
    logic              run;
    logic              mem_ready;
    logic [DATA_W-1:0] ir;
    logic              pc_out, zlo_out, zhi_out, mdr_out;
    logic              mar_enable, pc_enable, mdr_enable, ir_enable;
    logic              y_enable, z_enable, lo_enable, hi_enable;
    logic              read, pc_increment;
    logic [OPW-1:0]    op_code;
    logic [NREGS-1:0]  reg_in;
    logic [NREGS-1:0]  reg_out;
    logic              done, illegal;

    modport master (
        input  run, mem_ready, ir,
        output pc_out, zlo_out, zhi_out, mdr_out,
               mar_enable, pc_enable, mdr_enable, ir_enable,
               y_enable, z_enable, lo_enable, hi_enable,
               read, pc_increment, op_code, reg_in, reg_out, done, illegal
    );

    modport slave (
        output run, mem_ready, ir,
        input  pc_out, zlo_out, zhi_out, mdr_out,
               mar_enable, pc_enable, mdr_enable, ir_enable,
               y_enable, z_enable, lo_enable, hi_enable,
               read, pc_increment, op_code, reg_in, reg_out, done, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for fetch (T0..T2) and execute (T3..T6) of ALU, unary and mul/div ops.
// Outputs are registered together with the state, so each strobe is decoded for the state being entered.
module control_unit #(
    parameter int NREGS  = 16,
    parameter int OPW    = 5,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    control_unit_if.master   bus
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        C_BIN = 2'd0, C_UNARY = 2'd1, C_MULDIV = 2'd2, C_ILLEGAL = 2'd3
    } class_e;

    typedef struct packed {
        logic pc_out, zlo_out, zhi_out, mdr_out;
        logic mar_enable, pc_enable, mdr_enable, ir_enable;
        logic y_enable, z_enable, lo_enable, hi_enable;
        logic read, pc_increment, done, illegal;
        logic [OPW-1:0]   op_code;
        logic [NREGS-1:0] reg_in;
        logic [NREGS-1:0] reg_out;
    } ctrl_t;

    localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110, OP_SHL = 5'b00111, OP_ROR = 5'b01000;
    localparam logic [4:0] OP_ROL = 5'b01001, OP_AND = 5'b01010, OP_OR = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001, OP_NOT = 5'b10010;

    function automatic logic idx_ok(input logic [3:0] idx);
        return (32'(idx) < NREGS);
    endfunction

    function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
        logic [NREGS-1:0] v;
        if (idx_ok(idx)) begin
            v = NREGS'(1) << idx;
        end else begin
            v = '0;
        end
        return v;
    endfunction

    // An opcode is only executable if every register field it uses names an existing GPR.
    function automatic class_e classify(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
        class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
                c = (idx_ok(ra) && idx_ok(rb) && idx_ok(rc)) ? C_BIN : C_ILLEGAL;
            OP_MUL, OP_DIV:
                c = (idx_ok(rb) && idx_ok(rc)) ? C_MULDIV : C_ILLEGAL;
            OP_NEG, OP_NOT:
                c = (idx_ok(ra) && idx_ok(rb)) ? C_UNARY : C_ILLEGAL;
            default:
                c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    state_e      state_r;
    ctrl_t       ctrl_r;
    state_e      state_s;
    ctrl_t       ctrl_s;
    class_e      cls_s;
    logic [4:0]  op_s;
    logic [3:0]  ra_s, rb_s, rc_s;
    logic        unused_ir_s;

    assign op_s        = bus.ir[31:27];
    assign ra_s        = bus.ir[26:23];
    assign rb_s        = bus.ir[22:19];
    assign rc_s        = bus.ir[18:15];
    assign unused_ir_s = ^bus.ir[14:0];
    assign cls_s       = classify(op_s, ra_s, rb_s, rc_s);

    // Next-state selection; HALT is only left through clr.
    always_comb begin
        state_s = S_HALT;
        case (state_r)
            S_IDLE: state_s = bus.run ? S_T0 : S_IDLE;
            S_T0:   state_s = S_T1;
            S_T1:   state_s = bus.mem_ready ? S_T2 : S_T1;
            S_T2:   state_s = S_T3;
            S_T3:   state_s = (cls_s == C_ILLEGAL) ? S_HALT : S_T4;
            S_T4:   state_s = (cls_s == C_UNARY) ? S_IDLE : S_T5;
            S_T5:   state_s = (cls_s == C_MULDIV) ? S_T6 : S_IDLE;
            S_T6:   state_s = S_IDLE;
            S_HALT: state_s = S_HALT;
            default: state_s = S_HALT;
        endcase
    end

    // Strobes for the state about to be entered; pc_enable only on entry into T1, not while stalled there.
    always_comb begin
        ctrl_s = '0;
        case (state_s)
            S_T0: begin
                ctrl_s.pc_out       = 1'b1;
                ctrl_s.mar_enable   = 1'b1;
                ctrl_s.pc_increment = 1'b1;
                ctrl_s.z_enable     = 1'b1;
            end
            S_T1: begin
                ctrl_s.zlo_out    = 1'b1;
                ctrl_s.read       = 1'b1;
                ctrl_s.mdr_enable = 1'b1;
                ctrl_s.pc_enable  = (state_r != S_T1);
            end
            S_T2: begin
                ctrl_s.mdr_out   = 1'b1;
                ctrl_s.ir_enable = 1'b1;
            end
            S_T3: begin
                case (cls_s)
                    C_BIN, C_MULDIV: begin
                        ctrl_s.reg_out  = onehot(rb_s);
                        ctrl_s.y_enable = 1'b1;
                    end
                    C_UNARY: begin
                        ctrl_s.reg_out  = onehot(rb_s);
                        ctrl_s.op_code  = OPW'(op_s);
                        ctrl_s.z_enable = 1'b1;
                    end
                    default: ctrl_s.reg_out = '0;
                endcase
            end
            S_T4: begin
                case (cls_s)
                    C_BIN, C_MULDIV: begin
                        ctrl_s.reg_out  = onehot(rc_s);
                        ctrl_s.op_code  = OPW'(op_s);
                        ctrl_s.z_enable = 1'b1;
                    end
                    C_UNARY: begin
                        ctrl_s.zlo_out = 1'b1;
                        ctrl_s.reg_in  = onehot(ra_s);
                        ctrl_s.done    = 1'b1;
                    end
                    default: ctrl_s.reg_out = '0;
                endcase
            end
            S_T5: begin
                case (cls_s)
                    C_BIN: begin
                        ctrl_s.zlo_out = 1'b1;
                        ctrl_s.reg_in  = onehot(ra_s);
                        ctrl_s.done    = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl_s.zlo_out   = 1'b1;
                        ctrl_s.lo_enable = 1'b1;
                    end
                    default: ctrl_s.reg_in = '0;
                endcase
            end
            S_T6: begin
                ctrl_s.zhi_out   = 1'b1;
                ctrl_s.hi_enable = 1'b1;
                ctrl_s.done      = 1'b1;
            end
            S_HALT:  ctrl_s.illegal = 1'b1;
            default: ctrl_s = '0;
        endcase
    end

    // State and output registers; clr overrides everything, including a T1 stall.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= S_IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_s;
            ctrl_r  <= ctrl_s;
        end
    end

    assign bus.pc_out       = ctrl_r.pc_out;
    assign bus.zlo_out      = ctrl_r.zlo_out;
    assign bus.zhi_out      = ctrl_r.zhi_out;
    assign bus.mdr_out      = ctrl_r.mdr_out;
    assign bus.mar_enable   = ctrl_r.mar_enable;
    assign bus.pc_enable    = ctrl_r.pc_enable;
    assign bus.mdr_enable   = ctrl_r.mdr_enable;
    assign bus.ir_enable    = ctrl_r.ir_enable;
    assign bus.y_enable     = ctrl_r.y_enable;
    assign bus.z_enable     = ctrl_r.z_enable;
    assign bus.lo_enable    = ctrl_r.lo_enable;
    assign bus.hi_enable    = ctrl_r.hi_enable;
    assign bus.read         = ctrl_r.read;
    assign bus.pc_increment = ctrl_r.pc_increment;
    assign bus.done         = ctrl_r.done;
    assign bus.illegal      = ctrl_r.illegal;
    assign bus.op_code      = ctrl_r.op_code;
    assign bus.reg_in       = ctrl_r.reg_in;
    assign bus.reg_out      = ctrl_r.reg_out;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle against hand-computed strobes.
// Strobe word order: pc_out zlo zhi mdr_out mar pc_en mdr_en ir_en y z lo hi read pc_inc done illegal.
module tb_control_unit;
    localparam logic [15:0] ST_IDLE  = 16'h0000;
    localparam logic [15:0] ST_T0    = 16'h8844;
    localparam logic [15:0] ST_T1A   = 16'h4608;
    localparam logic [15:0] ST_T1S   = 16'h4208;
    localparam logic [15:0] ST_T2    = 16'h1100;
    localparam logic [15:0] ST_T3B   = 16'h0080;
    localparam logic [15:0] ST_ZEN   = 16'h0040;
    localparam logic [15:0] ST_WB    = 16'h4002;
    localparam logic [15:0] ST_LO    = 16'h4020;
    localparam logic [15:0] ST_HI    = 16'h2012;
    localparam logic [15:0] ST_HALT  = 16'h0001;

    localparam logic [31:0] IR_AND = 32'h5091_8000;
    localparam logic [31:0] IR_MUL = 32'h7822_8000;
    localparam logic [31:0] IR_NOT = 32'h9338_0000;
    localparam logic [31:0] IR_ADD = 32'h1891_8000;
    localparam logic [31:0] IR_BAD = 32'hF800_0000;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_pass   = 0;

    control_unit_if bus_if ();

    control_unit dut (.clk(clk), .clr(clr), .bus(bus_if.master));

    always #5 clk = ~clk;

    function automatic logic [15:0] strobes();
        return {bus_if.pc_out, bus_if.zlo_out, bus_if.zhi_out, bus_if.mdr_out,
                bus_if.mar_enable, bus_if.pc_enable, bus_if.mdr_enable, bus_if.ir_enable,
                bus_if.y_enable, bus_if.z_enable, bus_if.lo_enable, bus_if.hi_enable,
                bus_if.read, bus_if.pc_increment, bus_if.done, bus_if.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [15:0] s, input logic [4:0] op,
                              input logic [15:0] rin, input logic [15:0] rout);
        check({tag, ".strobes"}, 32'(strobes()), 32'(s));
        check({tag, ".op_code"}, 32'(bus_if.op_code), 32'(op));
        check({tag, ".reg_in"}, 32'(bus_if.reg_in), 32'(rin));
        check({tag, ".reg_out"}, 32'(bus_if.reg_out), 32'(rout));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads ir, raises run for exactly one edge; returns with the DUT in T0.
    task automatic launch(input logic [31:0] ir_v);
        bus_if.ir  = ir_v;
        bus_if.run = 1'b1;
        step();
        bus_if.run = 1'b0;
    endtask

    task automatic fetch(input string tag);
        expect_cyc({tag, ".t0"}, ST_T0, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc({tag, ".t1"}, ST_T1A, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc({tag, ".t2"}, ST_T2, 5'd0, 16'h0, 16'h0);
        step();
    endtask

    initial begin
        clr = 1'b1;
        bus_if.run = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.ir = 32'h0;
        step();
        step();
        expect_cyc("reset", ST_IDLE, 5'd0, 16'h0, 16'h0);
        clr = 1'b0;
        step();
        expect_cyc("idle", ST_IDLE, 5'd0, 16'h0, 16'h0);

        // and r1,r2,r3
        launch(IR_AND);
        fetch("and");
        expect_cyc("and.t3", ST_T3B, 5'd0, 16'h0, 16'h0004);
        step();
        expect_cyc("and.t4", ST_ZEN, 5'b01010, 16'h0, 16'h0008);
        step();
        expect_cyc("and.t5", ST_WB, 5'd0, 16'h0002, 16'h0);
        step();
        expect_cyc("and.end", ST_IDLE, 5'd0, 16'h0, 16'h0);

        // mul r0,r4,r5
        launch(IR_MUL);
        fetch("mul");
        expect_cyc("mul.t3", ST_T3B, 5'd0, 16'h0, 16'h0010);
        step();
        expect_cyc("mul.t4", ST_ZEN, 5'b01111, 16'h0, 16'h0020);
        step();
        expect_cyc("mul.t5", ST_LO, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc("mul.t6", ST_HI, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc("mul.end", ST_IDLE, 5'd0, 16'h0, 16'h0);

        // not r6,r7
        launch(IR_NOT);
        fetch("not");
        expect_cyc("not.t3", ST_ZEN, 5'b10010, 16'h0, 16'h0080);
        step();
        expect_cyc("not.t4", ST_WB, 5'd0, 16'h0040, 16'h0);
        step();
        expect_cyc("not.end", ST_IDLE, 5'd0, 16'h0, 16'h0);

        // T1 stall: mem_ready low for three T1 cycles, high in the fourth
        launch(IR_AND);
        bus_if.mem_ready = 1'b0;
        expect_cyc("stall.t0", ST_T0, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc("stall.t1a", ST_T1A, 5'd0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_cyc($sformatf("stall.t1s%0d", i), ST_T1S, 5'd0, 16'h0, 16'h0);
        end
        bus_if.mem_ready = 1'b1;
        step();
        expect_cyc("stall.t2", ST_T2, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc("stall.t3", ST_T3B, 5'd0, 16'h0, 16'h0004);
        step();
        step();
        expect_cyc("stall.t5", ST_WB, 5'd0, 16'h0002, 16'h0);
        step();

        // Illegal opcode halts until clr
        launch(IR_BAD);
        fetch("bad");
        expect_cyc("bad.t3", ST_IDLE, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc("bad.halt", ST_HALT, 5'd0, 16'h0, 16'h0);
        bus_if.run = 1'b1;
        step();
        expect_cyc("bad.hold", ST_HALT, 5'd0, 16'h0, 16'h0);
        bus_if.run = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        expect_cyc("bad.clr", ST_IDLE, 5'd0, 16'h0, 16'h0);
        step();

        // clr in T4 of add, then restart and back-to-back fetch with run held high
        launch(IR_ADD);
        fetch("add");
        step();
        expect_cyc("add.t4", ST_ZEN, 5'b00011, 16'h0, 16'h0008);
        clr = 1'b1;
        step();
        clr = 1'b0;
        bus_if.run = 1'b1;
        expect_cyc("add.clr", ST_IDLE, 5'd0, 16'h0, 16'h0);
        step();
        fetch("add2");
        step();
        step();
        expect_cyc("add2.t5", ST_WB, 5'd0, 16'h0002, 16'h0);
        step();
        expect_cyc("b2b.idle", ST_IDLE, 5'd0, 16'h0, 16'h0);
        step();
        expect_cyc("b2b.t0", ST_T0, 5'd0, 16'h0, 16'h0);
        bus_if.run = 1'b0;
        clr = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
